// File: rtl/life_scan_ctrl_if.sv
// Bundle between the life scan sequencer and its surroundings.
// It carries the run/step controls, the core's row data and cursor, the
// core addressing outputs, and the LED matrix drive.
interface life_scan_ctrl_if #(
    parameter int unsigned X     = 8,
    parameter int unsigned Y     = 8,
    parameter int unsigned LOG2X = 3,
    parameter int unsigned LOG2Y = 3
);
    logic                   run;
    logic                   step;
    logic [X-1:0]           row;
    logic [LOG2X-1:0]       cursor_x;
    logic [LOG2Y-1:0]       cursor_y;
    logic [LOG2X+LOG2Y-1:0] cnt;
    logic                   nxt_bit;
    logic                   busy;
    logic [Y-1:0]           row_sel;
    logic [X-1:0]           col_out;

    // Side that drives the controls and row data and observes the sequencer.
    modport master (
        output run, step, row, cursor_x, cursor_y,
        input  cnt, nxt_bit, busy, row_sel, col_out
    );

    // The sequencer itself.
    modport slave (
        input  run, step, row, cursor_x, cursor_y,
        output cnt, nxt_bit, busy, row_sel, col_out
    );
endinterface

// File: rtl/life_scan_ctrl.sv
// Life core sequencer.
// It alternates between two phases. In the display phase it scans the LED matrix
// one row per prescaler tick and overlays a blinking cursor. In the compute phase
// it walks every cell address with the nxt_bit strobe, one cell per clock.
module life_scan_ctrl #(
    parameter int unsigned X          = 8,
    parameter int unsigned Y          = 8,
    parameter int unsigned LOG2X      = 3,
    parameter int unsigned LOG2Y      = 3,
    parameter int unsigned PRESC_W    = 4,
    parameter int unsigned GEN_FRAMES = 4,
    parameter int unsigned BLINK_W    = 3
) (
    input  logic clk,
    input  logic reset,
    life_scan_ctrl_if.slave bus
);
    localparam int unsigned CW   = LOG2X + LOG2Y;
    localparam int unsigned FC_W = (GEN_FRAMES > 1) ? $clog2(GEN_FRAMES) : 1;

    localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(GEN_FRAMES - 1);
    localparam logic [LOG2Y-1:0] LAST_Y     = LOG2Y'(Y - 1);
    localparam logic [CW-1:0]    LAST_CELL  = CW'(X * Y - 1);

    typedef enum logic {DISP, CALC} state_t;

    state_t           state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [FC_W-1:0]  frame_q, frame_d;
    // One bit wider than BLINK_W, so the MSB toggles every 2^BLINK_W frames.
    logic [BLINK_W:0] blink_cnt_q, blink_cnt_d;
    logic             pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             nxt_bit_q, nxt_bit_d;
    logic             busy_q, busy_d;
    logic [Y-1:0]     row_sel_q, row_sel_d;
    logic [X-1:0]     col_out_q, col_out_d;

    logic             tick;
    logic             blink;
    logic             frame_end;
    logic [LOG2Y-1:0] y_cur;
    logic [LOG2Y-1:0] y_next;

    assign tick      = &presc_q;
    assign blink     = blink_cnt_q[BLINK_W];
    assign y_cur     = cnt_q[CW-1:LOG2X];
    assign y_next    = y_cur + LOG2Y'(1);
    assign frame_end = tick && (y_cur == LAST_Y);

    // Next-state logic for the scan/compute sequencer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q + PRESC_W'(1);
        frame_d     = frame_q;
        blink_cnt_d = blink_cnt_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        nxt_bit_d   = nxt_bit_q;
        busy_d      = busy_q;
        row_sel_d   = row_sel_q;
        col_out_d   = col_out_q;

        case (state_q)
            DISP: begin
                if (tick) begin
                    // Latch the row that has been addressed for the whole tick period.
                    // Then move the address on to the next row.
                    row_sel_d        = '0;
                    row_sel_d[y_cur] = 1'b1;
                    col_out_d        = bus.row;
                    if ((y_cur == bus.cursor_y) && blink) begin
                        col_out_d[bus.cursor_x] = ~bus.row[bus.cursor_x];
                    end
                    cnt_d = {y_next, {LOG2X{1'b0}}};

                    if (frame_end) begin
                        frame_d     = (frame_q == LAST_FRAME) ? '0 : frame_q + FC_W'(1);
                        blink_cnt_d = blink_cnt_q + (BLINK_W + 1)'(1);
                        if (pend_q || (bus.run && (frame_q == LAST_FRAME))) begin
                            state_d   = CALC;
                            cnt_d     = '0;
                            nxt_bit_d = 1'b1;
                            busy_d    = 1'b1;
                            row_sel_d = '0;
                            col_out_d = '0;
                            pend_d    = 1'b0;
                        end
                    end
                end
            end
            CALC: begin
                if (cnt_q == LAST_CELL) begin
                    state_d   = DISP;
                    cnt_d     = '0;
                    nxt_bit_d = 1'b0;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = DISP;
        endcase

        // A step request is never lost. One that arrives on the entry clock
        // re-arms pend and is serviced at the following frame end.
        if (bus.step) begin
            pend_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= DISP;
            presc_q     <= '0;
            frame_q     <= '0;
            blink_cnt_q <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            nxt_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            row_sel_q   <= '0;
            col_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            frame_q     <= frame_d;
            blink_cnt_q <= blink_cnt_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            nxt_bit_q   <= nxt_bit_d;
            busy_q      <= busy_d;
            row_sel_q   <= row_sel_d;
            col_out_q   <= col_out_d;
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.nxt_bit = nxt_bit_q;
    assign bus.busy    = busy_q;
    assign bus.row_sel = row_sel_q;
    assign bus.col_out = col_out_q;
endmodule

// File: tb/tb_life_scan_ctrl.sv
// Scoreboard bench for life_scan_ctrl.
// An event-level reference model pushes the expected display rows and compute
// bursts, each tagged with the clock edge at which it should appear.
// A separate monitor pops and compares whenever the DUT presents one.
module tb_life_scan_ctrl;
    localparam int unsigned X = 8, Y = 8, LOG2X = 3, LOG2Y = 3;
    localparam int unsigned PRESC_W = 4, GEN_FRAMES = 4, BLINK_W = 3;
    localparam int unsigned TICK_P = 1 << PRESC_W;
    localparam int unsigned CELLS  = X * Y;

    logic clk;
    logic reset;

    life_scan_ctrl_if #(.X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y)) bus ();

    life_scan_ctrl #(
        .X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y),
        .PRESC_W(PRESC_W), .GEN_FRAMES(GEN_FRAMES), .BLINK_W(BLINK_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    // Emulated core: row data for the addressed row, one clock after cnt changes.
    logic [X-1:0] mem [Y];
    always @(posedge clk) bus.row <= mem[bus.cnt[LOG2X+LOG2Y-1:LOG2X]];

    typedef struct {
        bit           is_calc;
        logic [Y-1:0] rs;
        logic [X-1:0] col;
        int unsigned  at;
    } ev_t;
    ev_t sb[$];

    // Reference model. It works in terms of ticks, rows, frames and bursts,
    // computed from the clock edge count since reset release.
    int unsigned edge_no = 0;
    int unsigned m_row = 0, m_frames = 0, m_calc_end = 0;
    bit          m_calc = 0, m_pend = 0;
    always @(posedge clk) begin
        if (!reset) begin
            edge_no = 0; m_row = 0; m_frames = 0; m_calc = 0; m_pend = 0;
        end else begin
            edge_no++;
            if (m_calc) begin
                if (edge_no == m_calc_end) begin
                    m_calc = 0;
                    m_row  = 0;
                end
            end else if (edge_no % TICK_P == 0) begin
                automatic bit last_row = (m_row == Y - 1);
                automatic bit auto_gen = bus.run && (m_frames % GEN_FRAMES == GEN_FRAMES - 1);
                if (last_row && (m_pend || auto_gen)) begin
                    sb.push_back('{1'b1, '0, '0, edge_no});
                    m_calc     = 1;
                    m_calc_end = edge_no + CELLS;
                    m_pend     = 0;
                end else begin
                    automatic logic [X-1:0] col = mem[m_row];
                    automatic logic [Y-1:0] rs  = '0;
                    rs[m_row] = 1'b1;
                    if (m_row == bus.cursor_y && ((m_frames >> BLINK_W) % 2 == 1))
                        col[bus.cursor_x] = ~col[bus.cursor_x];
                    sb.push_back('{1'b0, rs, col, edge_no});
                end
                if (last_row) m_frames++;
                m_row = (m_row + 1) % Y;
            end
            if (bus.step) m_pend = 1;
        end
    end

    // Monitor: consume expected events as the DUT presents them.
    bit           prev_nxt = 0;
    logic [Y-1:0] prev_rs  = '0;
    int unsigned  exp_cnt = 0, strobes = 0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_nxt = 0; prev_rs = '0; exp_cnt = 0; strobes = 0;
        end else begin
            while (sb.size() > 0 && sb[0].at < edge_no) begin
                chk("missed_event_edge", 64'(edge_no), 64'(sb[0].at));
                void'(sb.pop_front());
            end
            if (bus.nxt_bit && !prev_nxt) begin
                if (sb.size() == 0) chk("unexpected_calc", 1, 0);
                else begin
                    automatic ev_t e = sb.pop_front();
                    chk("calc_kind", 64'(e.is_calc), 1);
                    chk("calc_start_edge", 64'(edge_no), 64'(e.at));
                end
                exp_cnt = 0; strobes = 0;
            end
            if (bus.nxt_bit) begin
                chk("calc_cnt_busy_blank", {bus.cnt, bus.busy, bus.row_sel, bus.col_out},
                    {6'(exp_cnt), 1'b1, 8'h00, 8'h00});
                exp_cnt++; strobes++;
            end else if (prev_nxt) begin
                chk("calc_strobes", 64'(strobes), 64'(CELLS));
                chk("calc_exit_busy_cnt", {bus.busy, bus.cnt}, 7'h00);
            end else begin
                chk("disp_busy_cnt_x", {bus.busy, bus.cnt[LOG2X-1:0]}, 4'h0);
            end
            if (!bus.busy && bus.row_sel != prev_rs && bus.row_sel != '0) begin
                if (sb.size() == 0) chk("unexpected_row", 64'(bus.row_sel), 0);
                else begin
                    automatic ev_t e = sb.pop_front();
                    chk("row_kind", 64'(e.is_calc), 0);
                    chk("row_sel", 64'(bus.row_sel), 64'(e.rs));
                    chk("col_out", 64'(bus.col_out), 64'(e.col));
                    chk("row_edge", 64'(edge_no), 64'(e.at));
                end
            end
            prev_nxt = bus.nxt_bit;
            prev_rs  = bus.row_sel;
        end
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_step();
        @(negedge clk); bus.step = 1'b1;
        @(negedge clk); bus.step = 1'b0;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.busy) begin ok = 1; break; end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {bus.cnt, bus.nxt_bit, bus.busy, bus.row_sel, bus.col_out}, '0);
    endtask

    initial begin
        bit ok;
        reset = 1'b0;
        bus.run = 1'b0; bus.step = 1'b0;
        bus.cursor_x = '0; bus.cursor_y = 3'd3;
        for (int i = 0; i < Y; i++) mem[i] = 8'hA5;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        #2 reset = 1'b1;
        wait_clks(3);
        check_outputs_zero("pre_tick_outputs");

        // Constant A5 pattern across 11 frames: blink becomes visible from frame 8.
        wait_clks(11 * Y * TICK_P);

        // Single step pulse mid-frame, run low.
        wait_clks(37);
        pulse_step();
        wait_clks(3 * Y * TICK_P);

        // New row data and cursor, changed just after a tick edge.
        for (int i = 0; i < TICK_P; i++) begin
            @(negedge clk);
            if (edge_no % TICK_P == 0) break;
        end
        for (int i = 0; i < Y; i++) mem[i] = X'($urandom);
        bus.cursor_x = LOG2X'($urandom);
        bus.cursor_y = LOG2Y'($urandom);

        // Auto-run with sporadic random steps.
        bus.run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.step = ($urandom_range(0, 199) == 0);
        end
        bus.step = 1'b0;
        bus.run  = 1'b0;
        wait_clks(2 * Y * TICK_P);

        // Step while computing: the current burst completes and a second one follows.
        pulse_step();
        wait_busy(ok);
        chk("wait_busy_first", 64'(ok), 1);
        wait_clks(10);
        pulse_step();
        wait_clks(3 * Y * TICK_P);

        // Reset in the middle of a burst at cnt=20.
        pulse_step();
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.nxt_bit && bus.cnt == 6'd20) begin ok = 1; break; end
        end
        chk("wait_cnt20", 64'(ok), 1);
        #2 reset = 1'b0;
        sb.delete();
        #1 check_outputs_zero("async_reset_mid_calc");
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        wait_clks(3 * Y * TICK_P);

        @(negedge clk);
        #1 chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
